// File: rtl/arm_defs.sv
// Shared definitions for the SRAM controller slice:
// state encoding, default base address and external bus widths.
package arm_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
    localparam int          SRAM_ADDR_W    = 18;
    localparam int          SRAM_DATA_W    = 16;
    localparam int          WORD_W         = SRAM_ADDR_W - 1;
    localparam int          HOLD_CNT_W     = 4;

    // Word index = bits [18:2] of the wrapped byte offset.
    function automatic logic [WORD_W-1:0] word_index(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return WORD_W'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_hold_counter.sv
// Hold counter for one SRAM half-access: counts 0..HOLD_CYCLES-1,
// flags the last cycle and wraps so the next half starts from zero.
module sram_hold_counter
    import arm_defs::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [HOLD_CNT_W-1:0] LAST =
        HOLD_CNT_W'(HOLD_CYCLES - 1);

    logic [HOLD_CNT_W-1:0] cnt_q;
    logic [HOLD_CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + HOLD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// MEM-stage SRAM controller: each 32-bit access becomes a low then a
// high 16-bit half on the external SRAM, each held for HOLD_CYCLES.
module sram_controller
    import arm_defs::*;
#(
    parameter int          HOLD_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N
);

    sram_state_t       state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic [31:0]       rdata_q, rdata_d;

    logic                   busy;
    logic                   tc;
    logic                   dq_oe;
    logic [SRAM_DATA_W-1:0] dq_out;

    assign busy = (state_q == LO) || (state_q == HI);

    sram_hold_counter #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk(clk),
        .rst(rst),
        .clr(!busy),
        .en (busy),
        .tc (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Request inputs are only looked at in IDLE; write wins a tie.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        unique case (state_q)
            IDLE: begin
                if (rd_en || wr_en) begin
                    state_d = LO;
                    word_d  = word_index(address, BASE_ADDR);
                    wdata_d = write_data;
                    is_wr_d = wr_en;
                end
            end
            LO:      if (tc) state_d = HI;
            HI:      if (tc) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (!is_wr_q && tc) begin
            if (state_q == LO) rdata_d[15:0]  = SRAM_DQ;
            if (state_q == HI) rdata_d[31:16] = SRAM_DQ;
        end
    end

    always_comb begin
        ready     = 1'b0;
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        unique case (state_q)
            IDLE: ready = !(rd_en || wr_en);
            LO: begin
                SRAM_ADDR = {word_q, 1'b0};
                SRAM_WE_N = !is_wr_q;
                dq_oe     = is_wr_q;
                dq_out    = wdata_q[15:0];
            end
            HI: begin
                SRAM_ADDR = {word_q, 1'b1};
                SRAM_WE_N = !is_wr_q;
                dq_oe     = is_wr_q;
                dq_out    = wdata_q[31:16];
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 'z;
    assign read_data = rdata_q;

endmodule
